// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS main control FSM:
// opcodes, OpALU codes, state encodings and the bundled control-strobe record.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] op_alu;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control.sv
// Moore main-control FSM of the multicycle MIPS datapath.
// Define MIPS_ADDI_EN to add the ADDIEX/ADDIWB states for addi.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               IRWrite,
    output logic [1:0]         PCSource,
    output logic [1:0]         OpALU,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t     cur, nxt;
    logic [5:0] op_q;
    logic       illegal_q, illegal_d;
    ctrl_t      c;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= S_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            cur       <= nxt;
            illegal_q <= illegal_d;
            if (cur == S_DECODE)
                op_q <= opcode;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        nxt       = S_FETCH;
        illegal_d = 1'b0;
        case (cur)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
`ifdef MIPS_ADDI_EN
                    OP_ADDI:      nxt = S_ADDIEX;
`endif
                    default: begin
                        nxt       = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            // The opcode port may already carry the next instruction here.
            S_MEMADR: nxt = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt = S_MEMWB;
            S_EXEC:   nxt = S_ALUWB;
`ifdef MIPS_ADDI_EN
            S_ADDIEX: nxt = S_ADDIWB;
`endif
            default:  nxt = S_FETCH;
        endcase
    end

    always_comb begin
        c = '0;
        if (!reset) begin
            case (cur)
                S_FETCH: begin
                    c.mem_read  = 1'b1;
                    c.ir_write  = 1'b1;
                    c.alu_src_b = 2'b01;
                    c.op_alu    = ALUOP_ADD;
                    c.pc_write  = 1'b1;
                end
                S_DECODE: begin
                    c.alu_src_b = 2'b11;
                    c.op_alu    = ALUOP_ADD;
                end
                S_MEMADR: begin
                    c.alu_src_a = 1'b1;
                    c.alu_src_b = 2'b10;
                    c.op_alu    = ALUOP_ADD;
                end
                S_MEMRD: begin
                    c.mem_read = 1'b1;
                    c.iord     = 1'b1;
                end
                S_MEMWB: begin
                    c.reg_write  = 1'b1;
                    c.mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    c.mem_write = 1'b1;
                    c.iord      = 1'b1;
                end
                S_EXEC: begin
                    c.alu_src_a = 1'b1;
                    c.alu_src_b = 2'b00;
                    c.op_alu    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    c.reg_write = 1'b1;
                    c.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    c.alu_src_a     = 1'b1;
                    c.alu_src_b     = 2'b00;
                    c.op_alu        = ALUOP_SUB;
                    c.pc_write_cond = 1'b1;
                    c.pc_source     = 2'b01;
                end
                S_JUMP: begin
                    c.pc_write  = 1'b1;
                    c.pc_source = 2'b10;
                end
`ifdef MIPS_ADDI_EN
                S_ADDIEX: begin
                    c.alu_src_a = 1'b1;
                    c.alu_src_b = 2'b10;
                    c.op_alu    = ALUOP_ADD;
                end
                S_ADDIWB: c.reg_write = 1'b1;
`endif
                default: c = '0;
            endcase
        end
    end

    assign PCWrite     = c.pc_write;
    assign PCWriteCond = c.pc_write_cond;
    assign IorD        = c.iord;
    assign MemRead     = c.mem_read;
    assign MemWrite    = c.mem_write;
    assign MemtoReg    = c.mem_to_reg;
    assign IRWrite     = c.ir_write;
    assign PCSource    = c.pc_source;
    assign OpALU       = c.op_alu;
    assign ALUSrcA     = c.alu_src_a;
    assign ALUSrcB     = c.alu_src_b;
    assign RegWrite    = c.reg_write;
    assign RegDst      = c.reg_dst;
    assign illegal_op  = illegal_q & ~reset;
    assign state       = reset ? '0 : STATE_W'(cur);

endmodule
